// File: rtl/sram_dp_cfg_if.sv
// Bus bundle for sram_dp_cfg: user write port, read port and serial config loader.
// The master drives the requests and the slave (the memory) returns data and status.
interface sram_dp_cfg_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] wmask;
  logic                  re;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  cfg_start;
  logic                  cfg_en;
  logic                  cfg_din;
  logic                  cfg_busy;
  logic                  cfg_done;

  modport master (
    output we, waddr, wdata, wmask, re, raddr, cfg_start, cfg_en, cfg_din,
    input  rdata, rvalid, cfg_busy, cfg_done
  );

  modport slave (
    input  we, waddr, wdata, wmask, re, raddr, cfg_start, cfg_en, cfg_din,
    output rdata, rvalid, cfg_busy, cfg_done
  );
endinterface

// File: rtl/sram_dp_cfg.sv
// Simple-dual-port configuration SRAM with per-bit write mask, registered read
// (latency 1 or 2), selectable read-during-write policy and an LSB-first serial loader.
module sram_dp_cfg #(
  parameter int ADDR_WIDTH   = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int READ_LATENCY = 1,
  parameter int RDW_MODE     = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  sram_dp_cfg_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e                state_q, state_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [ADDR_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [DATA_WIDTH-1:0] shifted;
  logic                  ld_we;
  logic                  busy;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] wr_mask;
  logic [DATA_WIDTH-1:0] wr_word;
  logic [DATA_WIDTH-1:0] rd_word;

  logic [DATA_WIDTH-1:0] rd1_q, rd1_d;
  logic                  vld1_q, vld1_d;

  assign busy = (state_q == SHIFT);

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    sreg_d     = sreg_q;
    ld_we      = 1'b0;
    shifted    = {bus.cfg_din, sreg_q[DATA_WIDTH-1:1]};
    unique case (state_q)
      IDLE: begin
        if (bus.cfg_start) begin
          state_d    = SHIFT;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
        end
      end
      SHIFT: begin
        if (bus.cfg_en) begin
          sreg_d = shifted;
          // The word is written on its last bit, so the write uses the shifted value.
          if (bit_cnt_q == LAST_BIT) begin
            ld_we      = 1'b1;
            bit_cnt_d  = '0;
            word_cnt_d = word_cnt_q + ADDR_WIDTH'(1);
            if (word_cnt_q == '1) begin
              state_d = DONE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_en   = ld_we | (bus.we & ~busy);
    wr_addr = ld_we ? word_cnt_q : bus.waddr;
    wr_data = ld_we ? shifted : bus.wdata;
    wr_mask = ld_we ? {DATA_WIDTH{1'b1}} : bus.wmask;
    wr_word = (mem_q[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
  end

  // Old-data policy falls out of reading the array before the edge; new-data forwards the merge.
  always_comb begin
    rd_word = mem_q[bus.raddr];
    if ((RDW_MODE != 0) && wr_en && (wr_addr == bus.raddr)) begin
      rd_word = wr_word;
    end
    rd1_d  = bus.re ? rd_word : rd1_q;
    vld1_d = bus.re;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      sreg_q     <= '0;
      rd1_q      <= '0;
      vld1_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      sreg_q     <= sreg_d;
      rd1_q      <= rd1_d;
      vld1_q     <= vld1_d;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] rd2_q, rd2_d;
    logic                  vld2_q, vld2_d;

    always_comb begin
      rd2_d  = vld1_q ? rd1_q : rd2_q;
      vld2_d = vld1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd2_q  <= '0;
        vld2_q <= 1'b0;
      end else begin
        rd2_q  <= rd2_d;
        vld2_q <= vld2_d;
      end
    end

    assign bus.rdata  = rd2_q;
    assign bus.rvalid = vld2_q;
  end else begin : g_lat1
    assign bus.rdata  = rd1_q;
    assign bus.rvalid = vld1_q;
  end

  assign bus.cfg_busy = busy;
  assign bus.cfg_done = (state_q == DONE);
endmodule

// File: tb/tb_sram_dp_cfg.sv
// Bench for sram_dp_cfg: three instances (latency 1 old-data, latency 1 new-data,
// latency 2 old-data) share one stimulus and are checked against a word-level model.
module tb_sram_dp_cfg;
  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int NBITS = DW * DEPTH;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          we = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] wmask = '0;
  logic          re = 1'b0;
  logic [AW-1:0] raddr = '0;
  logic          cfg_start = 1'b0;
  logic          cfg_en = 1'b0;
  logic          cfg_din = 1'b0;

  int compared    = 0;
  int mismatched  = 0;
  int done_pulses = 0;

  always #5 clk = ~clk;

  sram_dp_cfg_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus [3] ();

  logic [DW-1:0] act_rdata  [3];
  logic          act_rvalid [3];
  logic          act_busy   [3];
  logic          act_done   [3];

  for (genvar g = 0; g < 3; g++) begin : g_bus
    assign bus[g].we        = we;
    assign bus[g].waddr     = waddr;
    assign bus[g].wdata     = wdata;
    assign bus[g].wmask     = wmask;
    assign bus[g].re        = re;
    assign bus[g].raddr     = raddr;
    assign bus[g].cfg_start = cfg_start;
    assign bus[g].cfg_en    = cfg_en;
    assign bus[g].cfg_din   = cfg_din;
    assign act_rdata[g]     = bus[g].rdata;
    assign act_rvalid[g]    = bus[g].rvalid;
    assign act_busy[g]      = bus[g].cfg_busy;
    assign act_done[g]      = bus[g].cfg_done;
  end

  sram_dp_cfg #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1), .RDW_MODE(0)) dut_l1_old (
    .clk(clk), .rst_n(rst_n), .bus(bus[0]));
  sram_dp_cfg #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1), .RDW_MODE(1)) dut_l1_new (
    .clk(clk), .rst_n(rst_n), .bus(bus[1]));
  sram_dp_cfg #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(2), .RDW_MODE(0)) dut_l2_old (
    .clk(clk), .rst_n(rst_n), .bus(bus[2]));

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Model: memory contents as words, the load as a running count of enabled bits.
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_kn  [DEPTH];
  bit            m_loading, m_done, was_loading;
  int            m_bits;
  logic [DW-1:0] m_buf;
  logic [DW-1:0] old_v, new_v, p_old;
  bit            old_k, new_k, p_kn, p_re;
  logic [DW-1:0] exp_rdata  [3];
  bit            exp_kn     [3];
  bit            exp_rvalid [3];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_loading = 1'b0;
      m_done    = 1'b0;
      m_bits    = 0;
      p_re      = 1'b0;
      for (int i = 0; i < 3; i++) begin
        exp_rdata[i]  = '0;
        exp_kn[i]     = 1'b1;
        exp_rvalid[i] = 1'b0;
      end
    end else begin
      old_v       = m_mem[raddr];
      old_k       = m_kn[raddr];
      was_loading = m_loading;
      if (m_done) begin
        m_done = 1'b0;
      end else if (m_loading) begin
        if (cfg_en) begin
          m_buf[m_bits % DW] = cfg_din;
          m_bits++;
          if (m_bits % DW == 0) begin
            m_mem[m_bits / DW - 1] = m_buf;
            m_kn[m_bits / DW - 1]  = 1'b1;
          end
          if (m_bits == NBITS) begin
            m_loading = 1'b0;
            m_done    = 1'b1;
          end
        end
      end else if (cfg_start) begin
        m_loading = 1'b1;
        m_bits    = 0;
      end
      if (!was_loading && we) begin
        m_mem[waddr] = (m_mem[waddr] & ~wmask) | (wdata & wmask);
        m_kn[waddr]  = m_kn[waddr] | (wmask == '1);
      end
      new_v = m_mem[raddr];
      new_k = m_kn[raddr];
      exp_rvalid[2] = p_re;
      if (p_re) begin
        exp_rdata[2] = p_old;
        exp_kn[2]    = p_kn;
      end
      p_re  = re;
      p_old = old_v;
      p_kn  = old_k;
      exp_rvalid[0] = re;
      exp_rvalid[1] = re;
      if (re) begin
        exp_rdata[0] = old_v;
        exp_kn[0]    = old_k;
        exp_rdata[1] = new_v;
        exp_kn[1]    = new_k;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("rvalid%0d", i), 32'(act_rvalid[i]), 32'(exp_rvalid[i]));
      checkOutput($sformatf("busy%0d", i), 32'(act_busy[i]), 32'(m_loading));
      checkOutput($sformatf("done%0d", i), 32'(act_done[i]), 32'(m_done));
      if (exp_kn[i]) begin
        checkOutput($sformatf("rdata%0d", i), 32'(act_rdata[i]), 32'(exp_rdata[i]));
      end
    end
    if (act_done[0]) done_pulses++;
  end

  task automatic applyStimulus(input logic s_we, input logic [AW-1:0] s_waddr,
                               input logic [DW-1:0] s_wdata, input logic [DW-1:0] s_wmask,
                               input logic s_re, input logic [AW-1:0] s_raddr,
                               input logic s_start, input logic s_en, input logic s_din);
    @(negedge clk);
    we        = s_we;
    waddr     = s_waddr;
    wdata     = s_wdata;
    wmask     = s_wmask;
    re        = s_re;
    raddr     = s_raddr;
    cfg_start = s_start;
    cfg_en    = s_en;
    cfg_din   = s_din;
  endtask

  task automatic applyIdle();
    applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic readWord(input logic [AW-1:0] a);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, a, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkResetState(input string tag);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("%s_rdata%0d", tag, i), 32'(act_rdata[i]), 32'h0);
      checkOutput($sformatf("%s_rvalid%0d", tag, i), 32'(act_rvalid[i]), 32'h0);
      checkOutput($sformatf("%s_busy%0d", tag, i), 32'(act_busy[i]), 32'h0);
      checkOutput($sformatf("%s_done%0d", tag, i), 32'(act_done[i]), 32'h0);
    end
  endtask

  // Word w of the image is (w*0x11)^xv; stops after max_bits enabled bits, user writes addr0 throughout.
  task automatic loadImage(input logic [DW-1:0] xv, input int max_bits, input bit pause_mid);
    logic [DW-1:0] wv;
    applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int w = 0; w < DEPTH; w++) begin
      wv = DW'(w * 17) ^ xv;
      for (int b = 0; b < DW; b++) begin
        if (w * DW + b == max_bits) return;
        if (pause_mid && w == 7 && b == 4) begin
          for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, '0, 8'hAA, 8'hFF, 1'b0, '0, (k == 1), 1'b0, 1'($urandom));
          end
        end
        applyStimulus(1'b1, '0, 8'hAA, 8'hFF, 1'b0, '0, 1'b0, 1'b1, wv[b]);
      end
    end
  endtask

  int done_before;

  initial begin
    #2 rst_n = 1'b0;
    #1 checkResetState("rst_immediate");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      re        = 1'($urandom);
      raddr     = AW'($urandom);
      wdata     = DW'($urandom);
      wmask     = DW'($urandom);
      cfg_start = 1'($urandom);
      cfg_en    = 1'($urandom);
      cfg_din   = 1'($urandom);
    end
    applyIdle();
    checkResetState("rst_held");
    #2 rst_n = 1'b1;

    writeSequence();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  task automatic writeSequence();
    // Masked write then readback.
    applyStimulus(1'b1, 4'd3, 8'hFF, 8'hFF, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd3, 8'h00, 8'h0F, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    readWord(4'd3);
    applyIdle();
    checkOutput("masked_rdata", 32'(act_rdata[0]), 32'hF0);
    checkOutput("masked_rvalid", 32'(act_rvalid[0]), 32'h1);
    applyIdle();
    checkOutput("masked_hold_rvalid", 32'(act_rvalid[0]), 32'h0);
    checkOutput("masked_hold_rdata", 32'(act_rdata[0]), 32'hF0);

    // Same-edge read and write to one address.
    applyStimulus(1'b1, 4'd5, 8'h11, 8'hFF, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd5, 8'h22, 8'hFF, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
    applyIdle();
    checkOutput("rdw_old", 32'(act_rdata[0]), 32'h11);
    checkOutput("rdw_new", 32'(act_rdata[1]), 32'h22);
    readWord(4'd5);
    applyIdle();
    checkOutput("rdw_after_old", 32'(act_rdata[0]), 32'h22);
    checkOutput("rdw_after_new", 32'(act_rdata[1]), 32'h22);
    applyIdle();

    // Full load with a pause, a stray start and blocked user writes.
    done_before = done_pulses;
    loadImage(8'h00, NBITS, 1'b1);
    checkOutput("load_busy_last_bit", 32'(act_busy[0]), 32'h1);
    applyIdle();
    checkOutput("load_done_pulse", 32'(act_done[0]), 32'h1);
    checkOutput("load_busy_in_done", 32'(act_busy[0]), 32'h0);
    applyIdle();
    checkOutput("load_done_clears", 32'(act_done[0]), 32'h0);
    applyIdle();
    checkOutput("load_done_count", 32'(done_pulses), 32'(done_before + 1));
    for (int a = 0; a < DEPTH; a++) readWord(AW'(a));
    applyIdle();
    checkOutput("load_addr15", 32'(act_rdata[0]), 32'hFF);
    readWord(4'd0);
    applyIdle();
    checkOutput("load_addr0_no_user_write", 32'(act_rdata[0]), 32'h00);
    readWord(4'd7);
    applyIdle();
    checkOutput("load_addr7_paused_word", 32'(act_rdata[0]), 32'h77);

    // Abort a load after 20 bits.
    loadImage(8'h5A, 20, 1'b0);
    applyIdle();
    #2 rst_n = 1'b0;
    #1 checkResetState("rst_midload");
    @(negedge clk);
    #2 rst_n = 1'b1;
    readWord(4'd0);
    applyIdle();
    checkOutput("abort_addr0", 32'(act_rdata[0]), 32'h5A);
    readWord(4'd1);
    applyIdle();
    checkOutput("abort_addr1", 32'(act_rdata[0]), 32'h4B);
    readWord(4'd2);
    applyIdle();
    checkOutput("abort_addr2_kept", 32'(act_rdata[0]), 32'h22);

    // Load again from address 0.
    done_before = done_pulses;
    loadImage(8'h00, NBITS, 1'b0);
    applyIdle();
    checkOutput("reload_done_pulse", 32'(act_done[0]), 32'h1);
    applyIdle();
    applyIdle();
    checkOutput("reload_done_count", 32'(done_pulses), 32'(done_before + 1));
    for (int a = 0; a < DEPTH; a++) readWord(AW'(a));
    applyIdle();
    readWord(4'd0);
    applyIdle();
    checkOutput("reload_addr0", 32'(act_rdata[0]), 32'h00);

    // Latency-2 pipeline with back-to-back reads.
    readWord(4'd1);
    readWord(4'd2);
    readWord(4'd3);
    checkOutput("lat2_first_valid", 32'(act_rvalid[2]), 32'h1);
    checkOutput("lat2_first_data", 32'(act_rdata[2]), 32'h11);
    applyIdle();
    checkOutput("lat2_second_valid", 32'(act_rvalid[2]), 32'h1);
    checkOutput("lat2_second_data", 32'(act_rdata[2]), 32'h22);
    applyIdle();
    checkOutput("lat2_third_valid", 32'(act_rvalid[2]), 32'h1);
    checkOutput("lat2_third_data", 32'(act_rdata[2]), 32'h33);
    applyIdle();
    checkOutput("lat2_end_valid", 32'(act_rvalid[2]), 32'h0);
    checkOutput("lat2_end_hold", 32'(act_rdata[2]), 32'h33);
    applyIdle();
    applyIdle();
  endtask
endmodule
